// File: rtl/dpb_bist.sv
// March-style write/read-back BIST for a single-port block RAM with 1- or 2-cycle read latency.
// Writes addr^seed to every location, reads everything back, and reports the mismatch count and the first failing address.
module dpb_bist #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] fail_addr
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam int                PAT_W    = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [1:0]        DRAIN_LAST = 2'(READ_LAT - 1);

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s);
        return DATA_W'(a[PAT_W-1:0]) ^ s;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            state, state_nx;
    logic [DATA_W-1:0] seed_q, seed_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [1:0]        drain_cnt, drain_nx;
    logic              clr;
    logic              done_nx, pass_nx;
    logic [15:0]       err_nx;
    logic [ADDR_W-1:0] fail_nx;
    logic              mismatch;

    logic              vld_p  [READ_LAT];
    logic [ADDR_W-1:0] addr_p [READ_LAT];
    logic [DATA_W-1:0] exp_p  [READ_LAT];

    // The oldest pipeline entry lines up with the RAM output in the same cycle
    assign mismatch = vld_p[READ_LAT-1] && (ram_dout != exp_p[READ_LAT-1]);

    always_comb begin
        err_nx  = err_count;
        fail_nx = fail_addr;
        if (clr) begin
            err_nx  = '0;
            fail_nx = '0;
        end else if (mismatch) begin
            err_nx = sat_inc(err_count);
            if (err_count == 16'd0)
                fail_nx = addr_p[READ_LAT-1];
        end
    end

    always_comb begin
        state_nx = state;
        seed_nx  = seed_q;
        addr_nx  = ram_ad;
        drain_nx = drain_cnt;
        done_nx  = done;
        pass_nx  = pass;
        clr      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = WRITE;
                    seed_nx  = seed;
                    addr_nx  = '0;
                    done_nx  = 1'b0;
                    pass_nx  = 1'b0;
                    clr      = 1'b1;
                end
            end
            WRITE: begin
                addr_nx = ram_ad + ADDR_W'(1);
                if (ram_ad == ADDR_MAX)
                    state_nx = READ;
            end
            READ: begin
                addr_nx = ram_ad + ADDR_W'(1);
                if (ram_ad == ADDR_MAX) begin
                    state_nx = DRAIN;
                    drain_nx = 2'd0;
                end
            end
            DRAIN: begin
                drain_nx = drain_cnt + 2'd1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    pass_nx  = (err_nx == 16'd0);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            seed_q    <= '0;
            drain_cnt <= '0;
            ram_ce    <= 1'b0;
            ram_oce   <= 1'b0;
            ram_wre   <= 1'b0;
            ram_ad    <= '0;
            ram_din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
        end else begin
            state     <= state_nx;
            seed_q    <= seed_nx;
            drain_cnt <= drain_nx;
            ram_ce    <= (state_nx == WRITE) || (state_nx == READ);
            ram_oce   <= (state_nx == READ) || (state_nx == DRAIN);
            ram_wre   <= (state_nx == WRITE);
            ram_ad    <= addr_nx;
            ram_din   <= (state_nx == WRITE) ? pattern(addr_nx, seed_nx) : '0;
            busy      <= (state_nx == WRITE) || (state_nx == READ) || (state_nx == DRAIN);
            done      <= done_nx;
            pass      <= pass_nx;
            err_count <= err_nx;
            fail_addr <= fail_nx;
        end
    end

    // Compare pipeline: stage 0 captures the read being issued this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                vld_p[i]  <= 1'b0;
                addr_p[i] <= '0;
                exp_p[i]  <= '0;
            end
        end else begin
            vld_p[0]  <= (state == READ);
            addr_p[0] <= ram_ad;
            exp_p[0]  <= pattern(ram_ad, seed_q);
            for (int i = 1; i < READ_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                addr_p[i] <= addr_p[i-1];
                exp_p[i]  <= exp_p[i-1];
            end
        end
    end

endmodule

// File: doc/dpb_bist.md
DPB_BIST -- requirements
Module: dpb_bist

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning RAM data width.
REQ-003 SHALL have parameter READ_LAT, default 2, meaning RAM read latency in cycles (legal values 1 or 2).
REQ-004 SHALL have port clk  input  1  meaning the single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  meaning reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  meaning a one-cycle test request.
REQ-007 SHALL have port seed  input  DATA_W  meaning the pattern seed, latched at start.
REQ-008 SHALL have port ram_ce  output  1  meaning RAM port clock enable.
REQ-009 SHALL have port ram_oce  output  1  meaning RAM output-register enable.
REQ-010 SHALL have port ram_wre  output  1  meaning RAM write enable.
REQ-011 SHALL have port ram_ad  output  ADDR_W  meaning RAM address.
REQ-012 SHALL have port ram_din  output  DATA_W  meaning RAM write data.
REQ-013 SHALL have port ram_dout  input  DATA_W  meaning RAM read data.
REQ-014 SHALL have port busy  output  1  meaning a test is in progress.
REQ-015 SHALL have port done  output  1  meaning the test has finished; held until the next start.
REQ-016 SHALL have port pass  output  1  meaning done with zero mismatches.
REQ-017 SHALL have port err_count  output  16  meaning the saturating mismatch count.
REQ-018 SHALL have port fail_addr  output  ADDR_W  meaning the address of the first mismatch.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, READ, DRAIN, DONE.
REQ-020 SHALL, in IDLE or DONE with start=1, latch seed, clear err_count/fail_addr/done/pass, set the address to 0, and enter WRITE next cycle; start SHALL be ignored in all other states.
REQ-021 SHALL, in WRITE, drive ram_ce=1 and ram_wre=1, with ram_din = ram_ad[DATA_W-1:0] XOR seed (zero-extended if ADDR_W<DATA_W), incrementing the address by 1 every cycle.
REQ-022 SHALL go from WRITE to READ after the write at address 2^ADDR_W-1, with the address wrapping to 0; no address is skipped or repeated.
REQ-023 SHALL, in READ, drive ram_ce=1 and ram_wre=0, issuing one address per cycle from 0 to 2^ADDR_W-1, then enter DRAIN.
REQ-024 SHALL assert ram_oce in READ and DRAIN, and hold it 0 otherwise.
REQ-025 SHALL carry each issued read address and its expected pattern through a READ_LAT-deep valid/addr/data pipeline, and compare against ram_dout when the entry emerges.
REQ-026 SHALL, on a mismatch, increment err_count, saturating at 16'hFFFF, and capture fail_addr only on the first mismatch of the test.
REQ-027 SHALL stay in DRAIN until the compare pipeline is empty (exactly READ_LAT cycles), then enter DONE.
REQ-028 SHALL, in DONE, assert done=1 and pass=(err_count==0), holding both until the next accepted start.
REQ-029 SHALL assert busy=1 exactly in WRITE, READ and DRAIN.
REQ-030 SHALL hold ram_ce=0 and ram_wre=0 in IDLE and DONE.
REQ-031 SHALL complete a test in exactly 2*2^ADDR_W+READ_LAT cycles from the first WRITE cycle to the first DONE cycle.
REQ-032 SHALL have all outputs registered.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force state IDLE, with all outputs 0, the address 0, and the compare pipeline cleared.
REQ-034 SHALL, on reset mid-test, abandon the test with no further RAM writes; a new test requires a fresh start.
REQ-035 SHALL leave reset synchronously on the first clk edge with rst_n=1.

Verification
REQ-036 Clean RAM model, ADDR_W=4, READ_LAT=2, seed=8'hA5, start pulse -> 16 writes with din(addr 3)=8'hA6, done after 34 cycles, pass=1, err_count=0.
REQ-037 Model forcing a read of addr 5 to return 8'h00, seed=8'h00 -> err_count=1, fail_addr=5, pass=0.
REQ-038 Stuck-at-zero model on all addresses, seed=8'hFF -> err_count=16, fail_addr=0.
REQ-039 Start pulsed during WRITE at cycle 3 -> ignored; total test length still 34 cycles.
REQ-040 rst_n low during READ at addr 7 -> next cycle all outputs 0 and busy=0; a later start runs a full clean test to pass=1.
REQ-041 READ_LAT=1 with a clean model, seed=8'h3C -> done after 33 cycles, pass=1.
